// File: rtl/addsub_accumulator.sv
// Accumulates N_OPS add/subtract operand beats into a signed ACC_W result with a
// sticky signed-overflow flag, presented on a valid/ready result handshake.
//
// state | meaning
// IDLE  | empty, waiting for the first beat of a result
// ACCUM | some beats accepted, waiting for the rest
// DONE  | result presented, waiting for out_ready
module addsub_accumulator #(
    parameter int N_OPS = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic             ovf, ovf_nxt;

    logic [4:0]       term5;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum;
    logic             step_ovf;
    logic             beat;
    logic             last_beat;

    // Add results are 0..30 and stay positive; differences wrap mod 32 and sign-extend.
    always_comb begin
        term5 = in_sub ? ({1'b0, in_a} - {1'b0, in_b}) : ({1'b0, in_a} + {1'b0, in_b});
        term  = in_sub ? {{(ACC_W-5){term5[4]}}, term5} : {{(ACC_W-5){1'b0}}, term5};
        sum   = acc + term;
        step_ovf = (acc[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    end

    // Handshake outputs decode the state register only.
    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_ovf   = ovf;

    assign beat      = in_valid && in_ready;
    assign last_beat = ((cnt + 4'd1) == 4'(N_OPS));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        case (state)
            IDLE, ACCUM: begin
                if (beat) begin
                    acc_nxt   = sum;
                    ovf_nxt   = ovf | step_ovf;
                    cnt_nxt   = cnt + 4'd1;
                    state_nxt = last_beat ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
                acc_nxt   = '0;
                ovf_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule
